// File: rtl/pipe_fwd_chain.sv
// pipe_fwd_chain: parametrised write-back pipeline with a stall/bubble controller
// and an NRD-port forwarding network. The youngest matching in-flight record wins.
// Optional build macro: PIPE_FWD_PERF_EN enables the saturating stall and bubble
// counters. Without it, stall_cnt_o and bubble_cnt_o are tied to zero.
module pipe_fwd_chain #(
    parameter int NSTAGE = 3,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              in_wreg_i,
    input  logic [AW-1:0]     in_wd_i,
    input  logic [DW-1:0]     in_wdata_i,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              flush_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              out_valid_o,
    output logic              out_wreg_o,
    output logic [AW-1:0]     out_wd_o,
    output logic [DW-1:0]     out_wdata_o,
    input  logic [NRD*AW-1:0] rd_addr_i,
    input  logic [NRD*DW-1:0] rd_data_i,
    output logic [NRD*DW-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_hit_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       bubble_cnt_o
);

    // Stage storage: stage NSTAGE-1 is the oldest and feeds the regfile.
    logic [NSTAGE-1:0] r_valid;
    logic [NSTAGE-1:0] r_wreg;
    logic [AW-1:0]     r_wd    [NSTAGE];
    logic [DW-1:0]     r_wdata [NSTAGE];

    // Hold vector and per-stage load source (stage s-1, or the execute record for s=0).
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_prev_stall;
    logic [NSTAGE-1:0] w_src_valid;
    logic [NSTAGE-1:0] w_src_wreg;
    logic [AW-1:0]     w_src_wd    [NSTAGE];
    logic [DW-1:0]     w_src_wdata [NSTAGE];

    // Forwarding scratch.
    logic [AW-1:0]     w_addr;
    logic              w_found;
    logic [DW-1:0]     w_fdata;

    // A stall request at stage j holds stage j and every younger stage.
    always_comb begin
        w_stall = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            w_stall[s] = |(stallreq_i >> s);
        end
    end

    assign stall_o = w_stall;

    // Select what each stage would load and whether its upstream neighbour is held.
    always_comb begin
        w_prev_stall[0] = 1'b0;
        w_src_valid[0]  = in_valid_i;
        w_src_wreg[0]   = in_wreg_i;
        w_src_wd[0]     = in_wd_i;
        w_src_wdata[0]  = in_wdata_i;
        for (int s = 1; s < NSTAGE; s++) begin
            w_prev_stall[s] = w_stall[s-1];
            w_src_valid[s]  = r_valid[s-1];
            w_src_wreg[s]   = r_wreg[s-1];
            w_src_wd[s]     = r_wd[s-1];
            w_src_wdata[s]  = r_wdata[s-1];
        end
    end

    // Stage update in priority order: flush, hold, bubble, then advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_wreg  <= '0;
            for (int s = 0; s < NSTAGE; s++) begin
                r_wd[s]    <= '0;
                r_wdata[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (flush_i) begin
                    // Flushed stages keep their payload; it is never looked at again.
                    r_valid[s] <= 1'b0;
                    r_wreg[s]  <= 1'b0;
                end else if (w_stall[s]) begin
                    r_valid[s] <= r_valid[s];
                    r_wreg[s]  <= r_wreg[s];
                end else if (w_prev_stall[s]) begin
                    r_valid[s] <= 1'b0;
                    r_wreg[s]  <= 1'b0;
                end else begin
                    r_valid[s] <= w_src_valid[s];
                    r_wreg[s]  <= w_src_wreg[s];
                    r_wd[s]    <= w_src_wd[s];
                    r_wdata[s] <= w_src_wdata[s];
                end
            end
        end
    end

    // A held last stage must not write the regfile a second time.
    assign out_valid_o = r_valid[NSTAGE-1] & ~stallreq_i[NSTAGE-1];
    assign out_wreg_o  = r_wreg[NSTAGE-1];
    assign out_wd_o    = r_wd[NSTAGE-1];
    assign out_wdata_o = r_wdata[NSTAGE-1];

    // Per-port bypass: youngest matching record wins, and r0 never forwards.
    always_comb begin
        rd_data_o = rd_data_i;
        rd_hit_o  = '0;
        w_addr    = '0;
        w_found   = 1'b0;
        w_fdata   = '0;
        for (int k = 0; k < NRD; k++) begin
            w_addr  = rd_addr_i[k*AW +: AW];
            w_found = 1'b0;
            w_fdata = '0;
            if (w_addr != {AW{1'b0}}) begin
                if (in_valid_i && in_wreg_i && (in_wd_i == w_addr)) begin
                    w_found = 1'b1;
                    w_fdata = in_wdata_i;
                end else begin
                    for (int s = 0; s < NSTAGE; s++) begin
                        if (!w_found && r_valid[s] && r_wreg[s] && (r_wd[s] == w_addr)) begin
                            w_found = 1'b1;
                            w_fdata = r_wdata[s];
                        end else begin
                            w_found = w_found;
                        end
                    end
                end
            end else begin
                w_found = 1'b0;
            end
            if (w_found) begin
                rd_data_o[k*DW +: DW] = w_fdata;
                rd_hit_o[k]           = 1'b1;
            end else begin
                rd_hit_o[k] = 1'b0;
            end
        end
    end

`ifdef PIPE_FWD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] w_bubbles;
    logic [32:0] w_bub_sum;

    // Count the bubbles inserted this cycle and form the widened sum used for saturation.
    always_comb begin
        w_bubbles = '0;
        for (int s = 0; s < NSTAGE; s++) begin
            if (!flush_i && !w_stall[s] && w_prev_stall[s]) begin
                w_bubbles = w_bubbles + 32'd1;
            end else begin
                w_bubbles = w_bubbles;
            end
        end
        w_bub_sum = {1'b0, r_bubble_cnt} + {1'b0, w_bubbles};
    end

    // Saturating performance counters; only reset clears them, a flush does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_stall[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_bub_sum[32]) begin
                r_bubble_cnt <= 32'hFFFF_FFFF;
            end else begin
                r_bubble_cnt <= w_bub_sum[31:0];
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`else
    assign stall_cnt_o  = 32'd0;
    assign bubble_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// Self-checking bench for pipe_fwd_chain (NSTAGE=3, DW=32, AW=5, NRD=2).
// A record-level reference model follows the pipeline rules. Directed scenarios
// come first, followed by a randomized stretch. When PIPE_FWD_PERF_EN is defined,
// counter checks use the modelled values; otherwise they expect zero.
module tb_pipe_fwd_chain;

    localparam int NS  = 3;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    typedef struct {
        logic        v;
        logic        w;
        logic [4:0]  wd;
        logic [31:0] d;
    } rec_t;

    logic              clk;
    logic              rst;
    logic              in_v;
    logic              in_w;
    logic [AW-1:0]     in_wd;
    logic [DW-1:0]     in_d;
    logic [NS-1:0]     sreq;
    logic              fl;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdi;
    logic [NS-1:0]     stall_o;
    logic              out_valid_o;
    logic              out_wreg_o;
    logic [AW-1:0]     out_wd_o;
    logic [DW-1:0]     out_wdata_o;
    logic [NRD*DW-1:0] rd_data_o;
    logic [NRD-1:0]    rd_hit_o;
    logic [31:0]       stall_cnt_o;
    logic [31:0]       bubble_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    rec_t             m_st [NS];
    longint unsigned  m_scnt;
    longint unsigned  m_bcnt;

    pipe_fwd_chain #(.NSTAGE(NS), .DW(DW), .AW(AW), .NRD(NRD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_v),
        .in_wreg_i    (in_w),
        .in_wd_i      (in_wd),
        .in_wdata_i   (in_d),
        .stallreq_i   (sreq),
        .flush_i      (fl),
        .stall_o      (stall_o),
        .out_valid_o  (out_valid_o),
        .out_wreg_o   (out_wreg_o),
        .out_wd_o     (out_wd_o),
        .out_wdata_o  (out_wdata_o),
        .rd_addr_i    (raddr),
        .rd_data_i    (rdi),
        .rd_data_o    (rd_data_o),
        .rd_hit_o     (rd_hit_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stage s is held when any stall request sits at s or further down the pipe.
    function automatic logic m_stall(input int s);
        logic r;
        r = 1'b0;
        for (int j = s; j < NS; j++) if (sreq[j]) r = 1'b1;
        return r;
    endfunction

    function automatic longint unsigned sat32(input longint unsigned x);
        return (x > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : x;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < NS; s++) m_st[s] = '{1'b0, 1'b0, 5'd0, 32'd0};
        m_scnt = 0;
        m_bcnt = 0;
    endtask

    task automatic m_tick();
        rec_t nxt [NS];
        int   bub;
        bub = 0;
        for (int s = 0; s < NS; s++) begin
            nxt[s] = m_st[s];
            if (fl) begin
                nxt[s].v = 1'b0;
                nxt[s].w = 1'b0;
            end else if (m_stall(s)) begin
                nxt[s] = m_st[s];
            end else if (s > 0 && m_stall(s - 1)) begin
                nxt[s].v = 1'b0;
                nxt[s].w = 1'b0;
                bub++;
            end else if (s == 0) begin
                nxt[s] = '{in_v, in_w, in_wd, in_d};
            end else begin
                nxt[s] = m_st[s-1];
            end
        end
        for (int s = 0; s < NS; s++) m_st[s] = nxt[s];
        if (m_stall(0)) m_scnt = sat32(m_scnt + 1);
        m_bcnt = sat32(m_bcnt + longint'(bub));
    endtask

    task automatic m_fwd(input logic [4:0] a, input logic [31:0] rf,
                         output logic [31:0] d, output logic h);
        rec_t c[$];
        c.push_back('{in_v, in_w, in_wd, in_d});
        for (int s = 0; s < NS; s++) c.push_back(m_st[s]);
        d = rf;
        h = 1'b0;
        if (a != 5'd0) begin
            foreach (c[i]) begin
                if (!h && c[i].v && c[i].w && c[i].wd == a) begin
                    h = 1'b1;
                    d = c[i].d;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        logic [NS-1:0] es;
        logic [31:0]   ed;
        logic          eh;
        for (int s = 0; s < NS; s++) es[s] = m_stall(s);
        chk({ctx, ".stall_o"}, 64'(stall_o), 64'(es));
        chk({ctx, ".out_valid"}, 64'(out_valid_o), 64'(m_st[NS-1].v & ~sreq[NS-1]));
        chk({ctx, ".out_wreg"}, 64'(out_wreg_o), 64'(m_st[NS-1].w));
        if (m_st[NS-1].v) begin
            chk({ctx, ".out_wd"}, 64'(out_wd_o), 64'(m_st[NS-1].wd));
            chk({ctx, ".out_wdata"}, 64'(out_wdata_o), 64'(m_st[NS-1].d));
        end
        for (int k = 0; k < NRD; k++) begin
            m_fwd(raddr[k*AW +: AW], rdi[k*DW +: DW], ed, eh);
            chk($sformatf("%s.rd_data%0d", ctx, k), 64'(rd_data_o[k*DW +: DW]), 64'(ed));
            chk($sformatf("%s.rd_hit%0d", ctx, k), 64'(rd_hit_o[k]), 64'(eh));
        end
`ifdef PIPE_FWD_PERF_EN
        chk({ctx, ".stall_cnt"}, 64'(stall_cnt_o), m_scnt);
        chk({ctx, ".bubble_cnt"}, 64'(bubble_cnt_o), m_bcnt);
`else
        chk({ctx, ".stall_cnt"}, 64'(stall_cnt_o), 64'd0);
        chk({ctx, ".bubble_cnt"}, 64'(bubble_cnt_o), 64'd0);
`endif
    endtask

    task automatic set_in(input logic v, input logic w, input logic [4:0] wd, input logic [31:0] d);
        in_v  = v;
        in_w  = w;
        in_wd = wd;
        in_d  = d;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
        raddr = {a1, a0};
        rdi   = {d1, d0};
    endtask

    // Advance one clock edge; returns 1 time unit after the edge.
    task automatic tick();
        m_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input string ctx);
        #1;
        check_all(ctx);
    endtask

    // Assert reset without a clock edge, check, then release on a falling edge.
    task automatic do_reset(input string ctx);
        rst = 1'b0;
        m_reset();
        #1;
        check_all(ctx);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        sreq = '0;
        fl   = 1'b0;
        set_rd(5'd5, 5'd0, 32'd9, 32'd9);
        do_reset("reset");

        // Latency: r5 <= A accepted at edge 0 appears after edge 2 for one cycle.
        set_in(1'b1, 1'b1, 5'd5, 32'hA);
        settle("lat0");
        tick();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        settle("lat1");
        chk("lat.e0_valid", 64'(out_valid_o), 64'd0);
        tick();
        settle("lat2");
        chk("lat.e1_valid", 64'(out_valid_o), 64'd0);
        tick();
        settle("lat3");
        chk("lat.e2_valid", 64'(out_valid_o), 64'd1);
        chk("lat.e2_wd", 64'(out_wd_o), 64'd5);
        chk("lat.e2_wdata", 64'(out_wdata_o), 64'hA);
        tick();
        settle("lat4");
        chk("lat.e3_valid", 64'(out_valid_o), 64'd0);

        // Priority: stage2 r5=7, stage1 r6, stage0 r5=1, then in r5=2.
        do_reset("prio_rst");
        set_in(1'b1, 1'b1, 5'd5, 32'd7);  tick();
        set_in(1'b1, 1'b1, 5'd6, 32'h66); tick();
        set_in(1'b1, 1'b1, 5'd5, 32'd1);  tick();
        set_in(1'b1, 1'b1, 5'd5, 32'd2);
        set_rd(5'd5, 5'd6, 32'd9, 32'd9);
        settle("prio_in");
        chk("prio.in_data", 64'(rd_data_o[31:0]), 64'd2);
        chk("prio.in_hit", 64'(rd_hit_o[0]), 64'd1);
        chk("prio.s1_data", 64'(rd_data_o[63:32]), 64'h66);
        set_in(1'b0, 1'b1, 5'd5, 32'd2);
        settle("prio_s0");
        chk("prio.s0_data", 64'(rd_data_o[31:0]), 64'd1);
        set_in(1'b1, 1'b1, 5'd0, 32'd3);
        set_rd(5'd0, 5'd0, 32'd9, 32'd9);
        settle("prio_r0");
        chk("prio.r0_data", 64'(rd_data_o[31:0]), 64'd9);
        chk("prio.r0_hit", 64'(rd_hit_o[0]), 64'd0);

        // Mid-stream stall at stage 1: stage 2 drains, a bubble goes into stage 2.
        do_reset("stall_rst");
        set_in(1'b1, 1'b1, 5'd1, 32'hC); tick();
        set_in(1'b1, 1'b1, 5'd2, 32'hB); tick();
        set_in(1'b1, 1'b1, 5'd3, 32'hA); tick();
        set_in(1'b1, 1'b1, 5'd4, 32'hD);
        sreq = 3'b010;
        set_rd(5'd3, 5'd1, 32'd0, 32'd0);
        settle("stall0");
        chk("stall.vec", 64'(stall_o), 64'b011);
        chk("stall.c_commit", 64'(out_valid_o), 64'd1);
        chk("stall.c_wd", 64'(out_wd_o), 64'd1);
        tick();
        sreq = 3'b000;
        settle("stall1");
        chk("stall.bubble_out", 64'(out_valid_o), 64'd0);
`ifdef PIPE_FWD_PERF_EN
        chk("stall.bubble_cnt", 64'(bubble_cnt_o), 64'd1);
`endif
        tick();
        settle("stall2");
        chk("stall.b_out", 64'(out_wd_o), 64'd2);

        // Flush together with a last-stage stall request.
        sreq = 3'b100;
        fl   = 1'b1;
        set_in(1'b1, 1'b1, 5'd7, 32'h77);
        settle("flush0");
        chk("flush.cur_valid", 64'(out_valid_o), 64'd0);
        tick();
        sreq = 3'b000;
        fl   = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        set_rd(5'd3, 5'd4, 32'h11, 32'h22);
        settle("flush1");
        chk("flush.out_valid", 64'(out_valid_o), 64'd0);
        chk("flush.hit", 64'(rd_hit_o), 64'd0);

        // Randomized stretch.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 7)), $urandom);
            sreq = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            fl   = ($urandom_range(0, 24) == 0);
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            settle("rand");
            tick();
        end
        sreq = '0;
        fl   = 1'b0;

`ifdef PIPE_FWD_PERF_EN
        // Stall counter saturation.
        sreq = 3'b001;
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        m_scnt = 64'hFFFF_FFFE;
        settle("sat0");
        for (int i = 0; i < 3; i++) begin
            tick();
            settle("sat");
        end
        chk("sat.stall_cnt", 64'(stall_cnt_o), 64'hFFFF_FFFF);
        sreq = 3'b000;
`endif

        // Reset mid-stream with three valid records in flight.
        set_in(1'b1, 1'b1, 5'd1, 32'h1); tick();
        set_in(1'b1, 1'b1, 5'd2, 32'h2); tick();
        set_in(1'b1, 1'b1, 5'd3, 32'h3); tick();
        set_in(1'b0, 1'b0, 5'd0, 32'd0);
        set_rd(5'd1, 5'd3, 32'd0, 32'd0);
        settle("pre_rst");
        chk("pre_rst.valid", 64'(out_valid_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst.valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst.hit", 64'(rd_hit_o), 64'd0);
        chk("mid_rst.scnt", 64'(stall_cnt_o), 64'd0);
        chk("mid_rst.bcnt", 64'(bubble_cnt_o), 64'd0);
        do_reset("mid_rst");
        settle("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
